// File: rtl/mod_addsub_pipe.sv
// Multi-lane modular add/sub/rsub/negate unit with a two-stage valid/ready pipeline.
// Latency: 2 cycles from input handshake to out_valid; throughput 1 transaction/cycle.
// Backpressure: in_ready is combinational from out_ready (no skid buffer); outputs hold while stalled.
module mod_addsub_pipe #(
    parameter int DATA_WIDTH = 12,
    parameter int MODULUS    = 3329,
    parameter int LANES      = 4,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_op,
    input  logic [LANES*DATA_WIDTH-1:0]   in_a,
    input  logic [LANES*DATA_WIDTH-1:0]   in_b,
    input  logic [TAG_WIDTH-1:0]          in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_res,
    output logic [TAG_WIDTH-1:0]          out_tag,
    output logic [LANES-1:0]              out_err,
    output logic [15:0]                   done_count
);
    // Two extra bits hold a+b without overflow and a signed difference.
    localparam int RW = DATA_WIDTH + 2;
    localparam logic [RW-1:0] Q = RW'(MODULUS);

    logic                        s1_valid;
    logic                        s2_valid;
    logic                        s2_load;
    logic                        in_hs;
    logic                        out_hs;
    logic [RW-1:0]               raw_d  [LANES];
    logic [RW-1:0]               s1_raw [LANES];
    logic [LANES-1:0]            err_d;
    logic [LANES-1:0]            s1_err;
    logic [TAG_WIDTH-1:0]        s1_tag;
    logic [LANES*DATA_WIDTH-1:0] res_d;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign in_hs     = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_hs    = s2_valid && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [RW-1:0] a_x;
        logic [RW-1:0] b_x;
        logic [RW-1:0] raw;
        logic [RW-1:0] fix;

        assign a_x = {2'b00, in_a[i*DATA_WIDTH +: DATA_WIDTH]};
        assign b_x = {2'b00, in_b[i*DATA_WIDTH +: DATA_WIDTH]};

        always_comb begin
            case (in_op)
                2'b00:   raw = a_x + b_x;
                2'b01:   raw = a_x - b_x;
                2'b10:   raw = b_x - a_x;
                default: raw = '0 - a_x;
            endcase
        end

        // Negate ignores b, so b cannot raise the range flag there.
        assign err_d[i] = (a_x >= Q) || ((in_op != 2'b11) && (b_x >= Q));
        assign raw_d[i] = raw;

        // A single conditional correction; sign bit selects the add-back path.
        always_comb begin
            if (s1_raw[i][RW-1])
                fix = s1_raw[i] + Q;
            else if (s1_raw[i] >= Q)
                fix = s1_raw[i] - Q;
            else
                fix = s1_raw[i];
        end

        assign res_d[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(fix);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_res    <= '0;
            out_tag    <= '0;
            out_err    <= '0;
            done_count <= '0;
        end else begin
            if (in_hs)
                s1_valid <= 1'b1;
            else if (s2_load)
                s1_valid <= 1'b0;

            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_res <= res_d;
                    out_tag <= s1_tag;
                    out_err <= s1_err;
                end
            end

            if (out_hs)
                done_count <= done_count + 16'd1;
        end
    end

    // Stage-1 payload is qualified by s1_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            s1_raw <= raw_d;
            s1_tag <= in_tag;
            s1_err <= err_d;
        end
    end
endmodule
